// File: rtl/text_buf_writer.sv
//============================================================================
// Module   : text_buf_writer
// Purpose  : Write side of the text overlay. Accepts 7-bit ASCII characters
//            over a valid/ready handshake, writes them into the character
//            tile RAM, tracks the cursor, and interprets CR, LF, BS and FF.
//            Entering a new line clears it. Form feed clears the whole screen.
// Options  : `define CURSOR_BLINK_EN makes the cursor blink with a
//            half-period of BLINK_CYCLES clocks. Without it, the cursor is
//            shown whenever no clear sweep is running.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module text_buf_writer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_in,
    output logic        char_ready,
    output logic        we,
    output logic [11:0] waddr,
    output logic [6:0]  wdata,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        cursor_on,
    output logic        busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_CLR_LINE = 2'd1;
    localparam logic [1:0] c_CLR_ALL  = 2'd2;

    localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);

    localparam logic [6:0] c_CH_BS    = 7'h08;
    localparam logic [6:0] c_CH_LF    = 7'h0A;
    localparam logic [6:0] c_CH_FF    = 7'h0C;
    localparam logic [6:0] c_CH_CR    = 7'h0D;

    // Reject geometries that cannot be addressed by the {row[4:0], col[6:0]} map
    generate
        if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 32 || BLINK_CYCLES < 1) begin : g_param_check
            $error("text_buf_writer: COLS/ROWS/BLINK_CYCLES out of range");
        end
    endgenerate

    logic [1:0] r_state;
    logic [6:0] r_cur_x;
    logic [4:0] r_cur_y;
    logic [6:0] r_clr_col;
    logic [4:0] r_clr_row;
    logic       r_we;
    logic [11:0] r_waddr;
    logic [6:0] r_wdata;

    logic       w_accept;
    logic       w_printable;
    logic [4:0] w_next_row;
    logic [6:0] w_x_dec;

    assign w_accept    = char_valid && (r_state == c_IDLE);
    assign w_printable = (char_in >= 7'h20) && (char_in <= 7'h7E);
    assign w_next_row  = (r_cur_y == c_LAST_ROW) ? 5'd0 : r_cur_y + 5'd1;
    assign w_x_dec     = r_cur_x - 7'd1;

    // Main state machine: character handling, cursor movement and clear sweeps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cur_x   <= 7'd0;
            r_cur_y   <= 5'd0;
            r_clr_col <= 7'd0;
            r_clr_row <= 5'd0;
            r_we      <= 1'b0;
            r_waddr   <= 12'd0;
            r_wdata   <= 7'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_we    <= 1'b1;
                            r_waddr <= {r_cur_y, r_cur_x};
                            r_wdata <= char_in;
                            if (r_cur_x == c_LAST_COL) begin
                                r_cur_x   <= 7'd0;
                                r_cur_y   <= w_next_row;
                                r_clr_col <= 7'd0;
                                r_state   <= c_CLR_LINE;
                            end else begin
                                r_cur_x <= r_cur_x + 7'd1;
                            end
                        end else begin
                            case (char_in)
                                c_CH_CR: r_cur_x <= 7'd0;
                                c_CH_LF: begin
                                    r_cur_y   <= w_next_row;
                                    r_clr_col <= 7'd0;
                                    r_state   <= c_CLR_LINE;
                                end
                                c_CH_BS: begin
                                    // Backspace never wraps to the previous row
                                    if (r_cur_x != 7'd0) begin
                                        r_cur_x <= w_x_dec;
                                        r_we    <= 1'b1;
                                        r_waddr <= {r_cur_y, w_x_dec};
                                        r_wdata <= 7'd0;
                                    end
                                end
                                c_CH_FF: begin
                                    r_clr_col <= 7'd0;
                                    r_clr_row <= 5'd0;
                                    r_state   <= c_CLR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                c_CLR_LINE: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_cur_y, r_clr_col};
                    r_wdata <= 7'd0;
                    if (r_clr_col == c_LAST_COL) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end
                c_CLR_ALL: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_clr_row, r_clr_col};
                    r_wdata <= 7'd0;
                    if (r_clr_col == c_LAST_COL) begin
                        r_clr_col <= 7'd0;
                        if (r_clr_row == c_LAST_ROW) begin
                            r_state <= c_IDLE;
                            r_cur_x <= 7'd0;
                            r_cur_y <= 5'd0;
                        end else begin
                            r_clr_row <= r_clr_row + 5'd1;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign char_ready = (r_state == c_IDLE);
    assign busy       = (r_state != c_IDLE);
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;

`ifdef CURSOR_BLINK_EN
    localparam int c_BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYCLES - 1);

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_on;

    // Blink timer: typing restarts the visible half-period so the cursor stays put while typing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_accept) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign cursor_on = r_blink_on & ~busy;
`else
    assign cursor_on = ~busy;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_buf_writer.sv
//============================================================================
// Module   : tb_text_buf_writer
// Purpose  : Self-checking bench for text_buf_writer. Includes directed
//            cases and a random character stream. All checks run against a
//            screen-level model of the expected write stream and cursor.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_text_buf_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [6:0]  char_in = 7'd0;
    logic        char_ready;
    logic        we;
    logic [11:0] waddr;
    logic [6:0]  wdata;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        cursor_on;
    logic        busy;

    always #5 clk = ~clk;

    text_buf_writer #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .BLINK_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .cursor_on  (cursor_on),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: cursor position plus the ordered list of RAM writes still expected
    int          m_x = 0;
    int          m_y = 0;
    logic [18:0] exp_q[$];

    function automatic void push_wr(input int row, input int col, input logic [6:0] d);
        exp_q.push_back({5'(row), 7'(col), d});
    endfunction

    function automatic void clear_row(input int row);
        for (int c = 0; c < COLS; c++) push_wr(row, c, 7'd0);
    endfunction

    function automatic void model_apply(input logic [6:0] ch);
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            push_wr(m_y, m_x, ch);
            m_x++;
            if (m_x == COLS) begin
                m_x = 0;
                m_y = (m_y + 1) % ROWS;
                clear_row(m_y);
            end
        end else if (ch == 7'h0D) begin
            m_x = 0;
        end else if (ch == 7'h0A) begin
            m_y = (m_y + 1) % ROWS;
            clear_row(m_y);
        end else if (ch == 7'h08) begin
            if (m_x > 0) begin
                m_x--;
                push_wr(m_y, m_x, 7'd0);
            end
        end else if (ch == 7'h0C) begin
            for (int r = 0; r < ROWS; r++) clear_row(r);
            m_x = 0;
            m_y = 0;
        end
    endfunction

    // Write monitor: every RAM write must match the next expected one
    logic [18:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", {31'b0, we}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write", {13'b0, waddr, wdata}, {13'b0, mon_e});
                end
            end
`ifndef CURSOR_BLINK_EN
            check("cursor_on", {31'b0, cursor_on}, {31'b0, ~busy});
`endif
        end
    end

    // Drive one character and hold it until accepted. Return how many cycles it waited.
    task automatic send(input logic [6:0] ch, output int waits);
        int guard;
        guard = 0;
        waits = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_in    = ch;
        while (!char_ready && guard < 5000) begin
            waits++;
            guard++;
            @(negedge clk);
        end
        if (!char_ready) begin
            check("accept_timeout", {31'b0, char_ready}, 32'd1);
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 char_valid = 1'b0;
            model_apply(ch);
        end
    endtask

    // Wait out any sweep, then compare the cursor to the model
    task automatic settle(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 5000) begin
            g++;
            @(negedge clk);
        end
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_x"},     {25'b0, cur_x}, m_x);
        check({tag, "_y"},     {27'b0, cur_y}, m_y);
        check({tag, "_ready"}, {31'b0, char_ready}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [6:0] ch;
        logic [6:0] others [5];
        int r;
        others[0] = 7'h00; others[1] = 7'h07; others[2] = 7'h1B;
        others[3] = 7'h7F; others[4] = 7'h01;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",     {31'b0, we}, 32'd0);
        check("rst_waddr",  {20'b0, waddr}, 32'd0);
        check("rst_wdata",  {25'b0, wdata}, 32'd0);
        check("rst_ready",  {31'b0, char_ready}, 32'd1);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_cursor", {31'b0, cursor_on}, 32'd1);
        check("rst_x",      {25'b0, cur_x}, 32'd0);
        check("rst_y",      {27'b0, cur_y}, 32'd0);
        reset = 1'b0;

        // 'A' at origin: latency-1 write, cursor advances
        send(7'h41, w);
        @(negedge clk);
        check("a_we",    {31'b0, we}, 32'd1);
        check("a_waddr", {20'b0, waddr}, 32'h000);
        check("a_wdata", {25'b0, wdata}, 32'h41);
        check("a_x",     {25'b0, cur_x}, 32'd1);
        check("a_y",     {27'b0, cur_y}, 32'd0);
        check("a_ready", {31'b0, char_ready}, 32'd1);

        // Fill the rest of row 0: last write at column 79, then row 1 clear
        for (int i = 0; i < COLS - 1; i++) send(7'h61 + 7'(i % 26), w);
        @(negedge clk);
        check("wrap_we",    {31'b0, we}, 32'd1);
        check("wrap_waddr", {20'b0, waddr}, 32'h04F);
        check("wrap_x",     {25'b0, cur_x}, 32'd0);
        check("wrap_y",     {27'b0, cur_y}, 32'd1);
        check("wrap_busy",  {31'b0, busy}, 32'd1);
        settle("wrap");

        // Move to (10,29), then LF wraps to row 0 and CR homes the column
        for (int i = 0; i < 28; i++) begin send(7'h0A, w); settle("lf_walk"); end
        for (int i = 0; i < 10; i++) send(7'h30, w);
        settle("pos_10_29");
        send(7'h0A, w);
        settle("lf_wrap");
        send(7'h0D, w);
        @(negedge clk);
        check("cr_we", {31'b0, we}, 32'd0);
        check("cr_x",  {25'b0, cur_x}, 32'd0);
        settle("cr");

        // Backspace from (5,3) then at column 0
        for (int i = 0; i < 3; i++) begin send(7'h0A, w); settle("lf3"); end
        for (int i = 0; i < 5; i++) send(7'h35, w);
        send(7'h08, w);
        @(negedge clk);
        check("bs_we",    {31'b0, we}, 32'd1);
        check("bs_waddr", {20'b0, waddr}, 32'h184);
        check("bs_wdata", {25'b0, wdata}, 32'd0);
        check("bs_x",     {25'b0, cur_x}, 32'd4);
        for (int i = 0; i < 4; i++) send(7'h08, w);
        send(7'h08, w);
        @(negedge clk);
        check("bs0_we", {31'b0, we}, 32'd0);
        check("bs0_x",  {25'b0, cur_x}, 32'd0);
        check("bs0_y",  {27'b0, cur_y}, 32'd3);

        // Form feed with a character held during the sweep
        send(7'h0C, w);
        send(7'h5A, w);
        check("ff_busy_cycles", w, 32'd2400);
        settle("ff_then_z");

        // Reset in the middle of a full clear
        send(7'h0C, w);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_we",    {31'b0, we}, 32'd0);
        check("mrst_busy",  {31'b0, busy}, 32'd0);
        check("mrst_ready", {31'b0, char_ready}, 32'd1);
        check("mrst_x",     {25'b0, cur_x}, 32'd0);
        check("mrst_y",     {27'b0, cur_y}, 32'd0);
        m_x = 0;
        m_y = 0;
        exp_q.delete();
        reset = 1'b0;

`ifdef CURSOR_BLINK_EN
        // Blink: on 4 cycles, off 4, and an accepted char restarts it visible
        send(7'h42, w);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("blink_a", {31'b0, cursor_on}, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end
        send(7'h43, w);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("blink_b", {31'b0, cursor_on}, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end
`endif

        // Random character stream
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 68)      ch = 7'($urandom_range(32, 126));
            else if (r < 78) ch = 7'h08;
            else if (r < 85) ch = 7'h0A;
            else if (r < 90) ch = 7'h0D;
            else if (r < 92) ch = 7'h0C;
            else             ch = others[$urandom_range(0, 4)];
            send(ch, w);
            settle("rand");
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
